// File: rtl/accel_axis_filter.sv
// Multi-axis moving-average filter with per-axis tilt classification and hysteresis.
// Optional build macro ACCEL_FILT_ROUND_EN selects round-half-up averaging instead of floor.
module accel_axis_filter #(
  parameter int N_CH        = 2,
  parameter int DATA_W      = 16,
  parameter int LOG2_DEPTH  = 4,
  parameter int TILT_THRESH = 64,
  parameter int HYST        = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         sample_valid,
  input  logic [N_CH*DATA_W-1:0]       sample_data,
  input  logic [$clog2(LOG2_DEPTH+1)-1:0] win_sel,
  input  logic                         flush,
  output logic [N_CH*DATA_W-1:0]       avg_data,
  output logic                         avg_valid,
  output logic [2*N_CH-1:0]            tilt,
  output logic                         primed,
  output logic                         busy,
  output logic                         overrun
);

  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam int SUM_W = DATA_W + LOG2_DEPTH;
  localparam int WS_W  = $clog2(LOG2_DEPTH + 1);
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int CNT_W = LOG2_DEPTH + 1;
  localparam logic signed [DATA_W-1:0] TH_POS = DATA_W'(TILT_THRESH);
  localparam logic signed [DATA_W-1:0] TH_NEG = DATA_W'(-TILT_THRESH);
  localparam logic signed [DATA_W-1:0] LV_POS = DATA_W'(TILT_THRESH - HYST);
  localparam logic signed [DATA_W-1:0] LV_NEG = DATA_W'(-(TILT_THRESH - HYST));

  typedef enum logic [1:0] {IDLE, RD, UPD, DONE} state_e;

  state_e                     state_q, state_d;
  logic [CH_W-1:0]            ch_q, ch_d;
  logic [N_CH*DATA_W-1:0]     smp_q, smp_d;
  logic [LOG2_DEPTH-1:0]      wptr_q, wptr_d;
  logic [CNT_W-1:0]           fill_q, fill_d;
  logic [WS_W-1:0]            wexp_q, wexp_d;
  logic signed [SUM_W-1:0]    sum_q [N_CH];
  logic signed [SUM_W-1:0]    sum_d [N_CH];
  logic [N_CH*DATA_W-1:0]     avg_q, avg_d;
  logic [2*N_CH-1:0]          tilt_q, tilt_d;
  logic                       avg_valid_q, avg_valid_d;
  logic                       primed_q, primed_d;
  logic                       overrun_q, overrun_d;
  logic                       busy_q, busy_d;

  logic [DATA_W-1:0]          mem_q [N_CH][DEPTH];
  logic [DATA_W-1:0]          rd_data_q;

  logic [WS_W-1:0]            win_eff_s;
  logic [CNT_W-1:0]           win_len_s;
  logic [LOG2_DEPTH-1:0]      rd_addr_s;
  logic signed [DATA_W-1:0]   cur_smp_s;
  logic signed [DATA_W-1:0]   oldest_s;
  logic signed [SUM_W-1:0]    new_sum_s;
  logic signed [SUM_W:0]      rnd_sum_s;
  logic signed [DATA_W-1:0]   new_avg_s;
  logic                       win_chg_s;
  logic                       mem_we_s;

  // Three-state tilt classifier; leaving a tilt state needs the smaller hysteresis level.
  function automatic logic [1:0] tilt_next(input logic [1:0] cur, input logic signed [DATA_W-1:0] a);
    logic [1:0] nxt;
    case (cur)
      2'b00: begin
        if (a > TH_POS)      nxt = 2'b01;
        else if (a < TH_NEG) nxt = 2'b10;
        else                 nxt = 2'b00;
      end
      2'b01: begin
        if (a < TH_NEG)      nxt = 2'b10;
        else if (a < LV_POS) nxt = 2'b00;
        else                 nxt = 2'b01;
      end
      2'b10: begin
        if (a > TH_POS)      nxt = 2'b01;
        else if (a > LV_NEG) nxt = 2'b00;
        else                 nxt = 2'b10;
      end
      default: nxt = 2'b00;
    endcase
    return nxt;
  endfunction

  // Datapath: oldest-entry selection, running-sum update and scaled average.
  always_comb begin
    win_eff_s = (win_sel > WS_W'(LOG2_DEPTH)) ? WS_W'(LOG2_DEPTH) : win_sel;
    win_len_s = CNT_W'(1) << wexp_q;
    rd_addr_s = wptr_q - win_len_s[LOG2_DEPTH-1:0];
    cur_smp_s = smp_q[ch_q*DATA_W +: DATA_W];
    // Until the window has filled, the slot W back holds stale data and counts as zero.
    oldest_s  = (fill_q < win_len_s) ? {DATA_W{1'b0}} : rd_data_q;
    new_sum_s = sum_q[ch_q] + SUM_W'(cur_smp_s) - SUM_W'(oldest_s);
`ifdef ACCEL_FILT_ROUND_EN
    if (wexp_q == WS_W'(0)) begin
      rnd_sum_s = {new_sum_s[SUM_W-1], new_sum_s};
    end else begin
      rnd_sum_s = {new_sum_s[SUM_W-1], new_sum_s} + ((SUM_W+1)'(1) << (wexp_q - WS_W'(1)));
    end
`else
    rnd_sum_s = {new_sum_s[SUM_W-1], new_sum_s};
`endif
    new_avg_s = DATA_W'(rnd_sum_s >>> wexp_q);
  end

  // Next-state and output-register logic; flush and window changes override all else.
  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    smp_d       = smp_q;
    wptr_d      = wptr_q;
    fill_d      = fill_q;
    wexp_d      = wexp_q;
    avg_d       = avg_q;
    tilt_d      = tilt_q;
    primed_d    = primed_q;
    overrun_d   = overrun_q;
    avg_valid_d = 1'b0;
    mem_we_s    = 1'b0;
    for (int c = 0; c < N_CH; c++) sum_d[c] = sum_q[c];
    win_chg_s   = (state_q == IDLE) && (win_eff_s != wexp_q);

    if (flush || win_chg_s) begin
      state_d   = IDLE;
      ch_d      = {CH_W{1'b0}};
      wptr_d    = {LOG2_DEPTH{1'b0}};
      fill_d    = {CNT_W{1'b0}};
      avg_d     = {(N_CH*DATA_W){1'b0}};
      tilt_d    = {(2*N_CH){1'b0}};
      primed_d  = 1'b0;
      overrun_d = 1'b0;
      wexp_d    = win_chg_s ? win_eff_s : wexp_q;
      for (int c = 0; c < N_CH; c++) sum_d[c] = {SUM_W{1'b0}};
    end else begin
      if (sample_valid && (state_q != IDLE)) overrun_d = 1'b1;
      else                                   overrun_d = overrun_q;
      case (state_q)
        IDLE: begin
          if (sample_valid) begin
            smp_d   = sample_data;
            ch_d    = {CH_W{1'b0}};
            state_d = RD;
          end else begin
            state_d = IDLE;
          end
        end
        RD: state_d = UPD;
        UPD: begin
          sum_d[ch_q]                   = new_sum_s;
          mem_we_s                      = 1'b1;
          avg_d[ch_q*DATA_W +: DATA_W]  = new_avg_s;
          tilt_d[ch_q*2 +: 2]           = tilt_next(tilt_q[ch_q*2 +: 2], new_avg_s);
          if (ch_q == CH_W'(N_CH - 1)) begin
            state_d     = DONE;
            avg_valid_d = 1'b1;
            primed_d    = primed_q | ((fill_q + CNT_W'(1)) >= win_len_s);
          end else begin
            ch_d    = ch_q + CH_W'(1);
            state_d = RD;
          end
        end
        DONE: begin
          wptr_d  = wptr_q + LOG2_DEPTH'(1);
          fill_d  = (fill_q < win_len_s) ? fill_q + CNT_W'(1) : fill_q;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      ch_q        <= {CH_W{1'b0}};
      smp_q       <= {(N_CH*DATA_W){1'b0}};
      wptr_q      <= {LOG2_DEPTH{1'b0}};
      fill_q      <= {CNT_W{1'b0}};
      wexp_q      <= {WS_W{1'b0}};
      avg_q       <= {(N_CH*DATA_W){1'b0}};
      tilt_q      <= {(2*N_CH){1'b0}};
      avg_valid_q <= 1'b0;
      primed_q    <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
      for (int c = 0; c < N_CH; c++) sum_q[c] <= {SUM_W{1'b0}};
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      smp_q       <= smp_d;
      wptr_q      <= wptr_d;
      fill_q      <= fill_d;
      wexp_q      <= wexp_d;
      avg_q       <= avg_d;
      tilt_q      <= tilt_d;
      avg_valid_q <= avg_valid_d;
      primed_q    <= primed_d;
      overrun_q   <= overrun_d;
      busy_q      <= busy_d;
      for (int c = 0; c < N_CH; c++) sum_q[c] <= sum_d[c];
    end
  end

  // History buffer: read in RD, written in UPD; contents are deliberately never cleared.
  always_ff @(posedge clk) begin
    if (mem_we_s) mem_q[ch_q][wptr_q] <= cur_smp_s;
    rd_data_q <= mem_q[ch_q][rd_addr_s];
  end

  assign avg_data  = avg_q;
  assign avg_valid = avg_valid_q;
  assign tilt      = tilt_q;
  assign primed    = primed_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_accel_axis_filter.sv
// Directed, table-driven bench for accel_axis_filter (N_CH=2, DATA_W=16, W up to 16).
module tb_accel_axis_filter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        sample_valid;
  logic [31:0] sample_data;
  logic [2:0]  win_sel;
  logic        flush;
  logic [31:0] avg_data;
  logic        avg_valid;
  logic [3:0]  tilt;
  logic        primed, busy, overrun;

  int checks = 0;
  int errors = 0;

`ifdef ACCEL_FILT_ROUND_EN
  localparam int RND = 1;
`else
  localparam int RND = 0;
`endif

  typedef struct {
    int         x;
    int         y;
    int         ex;
    int         ey;
    logic [3:0] et;
    logic       ep;
  } vec_t;

  vec_t tv[12];

  accel_axis_filter dut (
    .clk(clk), .reset_n(reset_n), .sample_valid(sample_valid), .sample_data(sample_data),
    .win_sel(win_sel), .flush(flush), .avg_data(avg_data), .avg_valid(avg_valid),
    .tilt(tilt), .primed(primed), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  function automatic int avg_x();
    logic signed [15:0] v;
    v = avg_data[15:0];
    return int'(v);
  endfunction

  function automatic int avg_y();
    logic signed [15:0] v;
    v = avg_data[31:16];
    return int'(v);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Present one sample set; returns negedges from accept to avg_valid (0 = never seen).
  task automatic send(input int x, input int y, output int lat);
    @(negedge clk);
    sample_valid = 1'b1;
    sample_data  = {16'(y), 16'(x)};
    @(negedge clk);
    sample_valid = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      if (lat == 0) begin
        @(negedge clk);
        if (avg_valid) lat = i;
      end
    end
    if (lat == 0) chk("avg_valid_timeout", 0, 1);
  endtask

  task automatic pulse_flush();
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int n;

    tv[0]  = '{100, -100,  25,  -25, 4'b0000, 1'b0};
    tv[1]  = '{100, -100,  50,  -50, 4'b0000, 1'b0};
    tv[2]  = '{100, -100,  75,  -75, 4'b1001, 1'b0};
    tv[3]  = '{100, -100, 100, -100, 4'b1001, 1'b1};
    tv[4]  = '{ 60, -100,  90, -100, 4'b1001, 1'b1};
    tv[5]  = '{ 60, -100,  80, -100, 4'b1001, 1'b1};
    tv[6]  = '{ 60, -100,  70, -100, 4'b1001, 1'b1};
    tv[7]  = '{ 60, -100,  60, -100, 4'b1001, 1'b1};
    tv[8]  = '{ 40, -100,  55, -100, 4'b1001, 1'b1};
    tv[9]  = '{ 40, -100,  50, -100, 4'b1001, 1'b1};
    tv[10] = '{ 40, -100,  45, -100, 4'b1000, 1'b1};
    tv[11] = '{ 40, -100,  40, -100, 4'b1000, 1'b1};

    // Reset with random inputs
    reset_n = 1'b0;
    sample_valid = 1'b0; sample_data = 32'd0; win_sel = 3'd0; flush = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      sample_valid = 1'($urandom_range(0, 1));
      sample_data  = $urandom;
      win_sel      = 3'($urandom_range(0, 7));
      flush        = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    chk("rst_avg_data", int'(avg_data), 0);
    chk("rst_avg_valid", int'(avg_valid), 0);
    chk("rst_tilt", int'(tilt), 0);
    chk("rst_primed", int'(primed), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_overrun", int'(overrun), 0);
    sample_valid = 1'b0; sample_data = 32'd0; win_sel = 3'd0; flush = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;

    // Latency at W=1
    send(11, -4, lat);
    chk("latency", lat, 4);
    chk("w1_avg_x", avg_x(), 11);
    chk("w1_avg_y", avg_y(), -4);

    // Priming and hysteresis at W=4
    @(negedge clk); win_sel = 3'd2;
    @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      send(tv[i].x, tv[i].y, lat);
      chk($sformatf("vec%0d_avg_x", i), avg_x(), tv[i].ex);
      chk($sformatf("vec%0d_avg_y", i), avg_y(), tv[i].ey);
      chk($sformatf("vec%0d_tilt", i), int'(tilt), int'(tv[i].et));
      chk($sformatf("vec%0d_primed", i), int'(primed), int'(tv[i].ep));
    end

    // Overrun: second strobe one cycle after accept is dropped
    @(negedge clk);
    sample_valid = 1'b1; sample_data = {16'(0), 16'(100)};
    @(negedge clk);
    @(negedge clk);
    sample_valid = 1'b0;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (avg_valid) n++;
    end
    chk("ovr_pulses", n, 1);
    chk("ovr_flag", int'(overrun), 1);
    pulse_flush();
    chk("flush_overrun", int'(overrun), 0);
    chk("flush_primed", int'(primed), 0);
    chk("flush_avg_data", int'(avg_data), 0);
    chk("flush_tilt", int'(tilt), 0);

    // Flush mid-sample aborts it without avg_valid or overrun
    @(negedge clk);
    sample_valid = 1'b1; sample_data = {16'(7), 16'(7)};
    @(negedge clk);
    sample_valid = 1'b0; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (avg_valid) n++;
    end
    chk("abort_pulses", n, 0);
    chk("abort_overrun", int'(overrun), 0);
    chk("abort_busy", int'(busy), 0);

    // Window change 2 -> 0 flushes and W becomes 1
    for (int i = 0; i < 4; i++) send(100, -100, lat);
    chk("reprime_primed", int'(primed), 1);
    chk("reprime_avg_x", avg_x(), 100);
    @(negedge clk); win_sel = 3'd0;
    @(negedge clk);
    chk("winchg_primed", int'(primed), 0);
    chk("winchg_tilt", int'(tilt), 0);
    send(-7, 5, lat);
    chk("w1b_avg_x", avg_x(), -7);
    chk("w1b_avg_y", avg_y(), 5);
    chk("w1b_primed", int'(primed), 1);
    chk("w1b_tilt", int'(tilt), 0);

    // Rounding behaviour at fresh W=4
    @(negedge clk); win_sel = 3'd2;
    @(negedge clk);
    send(3, -3, lat);
    chk("rnd_pos_x", avg_x(), RND);
    chk("rnd_neg_y", avg_y(), -1);
    pulse_flush();
    send(-3, 3, lat);
    chk("rnd_neg_x", avg_x(), -1);
    chk("rnd_pos_y", avg_y(), RND);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
